user_obi_arb: RTL and testbench

Round-robin OBI arbiter that shares one OBI subordinate port (e.g. the user-domain signature ROM or any in-order user peripheral) between `NumMgr` OBI managers in the user domain. It forwards one manager's A-channel request per cycle, records which manager won each accepted transaction in a small in-order queue, and routes each returning R-channel response back to that manager. It sits between the user-domain crossbar ports and a single subordinate.

---
 rtl/user_obi_arb_pkg.sv | 74 +++++++
 rtl/user_obi_arb_fifo.sv | 69 ++++++
 rtl/user_obi_arb.sv | 124 ++++++++++++
 tb/tb_user_obi_arb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_obi_arb_pkg.sv
//------------------------------------------------------------------------------
// user_obi_arb_pkg -- default OBI types, configuration and round-robin helper.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package user_obi_arb_pkg;

    localparam int unsigned MaxNumMgr = 8;
    localparam int unsigned MgrIdxW   = $clog2(MaxNumMgr);

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 4;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth,
        IdWidth:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } def_a_chan_t;

    typedef struct packed {
        def_a_chan_t a;
        logic        req;
    } def_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
        logic                    r_optional;
    } def_r_chan_t;

    typedef struct packed {
        def_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } def_rsp_t;

    // First requesting index at or above ptr, wrapping. Unused upper request
    // bits must be zero so the wrap is effectively modulo the real manager count.
    function automatic logic [MgrIdxW-1:0] rr_select(
        input logic [MaxNumMgr-1:0] req_vec,
        input logic [MgrIdxW-1:0]   ptr
    );
        logic [MgrIdxW-1:0] win;
        logic [MgrIdxW-1:0] idx;
        win = ptr;
        for (int k = MaxNumMgr - 1; k >= 0; k--) begin
            idx = ptr + MgrIdxW'(k);
            if (req_vec[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/user_obi_arb_fifo.sv
//------------------------------------------------------------------------------
// user_obi_arb_fifo -- in-order index queue recording the winner of each accepted transaction.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module user_obi_arb_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/user_obi_arb.sv
//------------------------------------------------------------------------------
// user_obi_arb -- round-robin OBI arbiter, NumMgr managers onto one in-order subordinate.
// Define USER_OBI_ARB_FIXED_PRIO_EN for fixed lowest-index priority.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module user_obi_arb
    import user_obi_arb_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
    parameter type         obi_req_t = def_req_t,
    parameter type         obi_rsp_t = def_rsp_t,
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned MaxTrans  = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t mgr_req_i [NumMgr],
    output obi_rsp_t mgr_rsp_o [NumMgr],
    output obi_req_t sbr_req_o,
    input  obi_rsp_t sbr_rsp_i
);

    localparam int unsigned IdxW = $clog2(NumMgr);
    localparam int unsigned CntW = $clog2(MaxTrans) + 1;

    logic [MaxNumMgr-1:0] req_vec;
    logic                 any_req;
    logic [IdxW-1:0]      rr_ptr_q;
    logic [IdxW-1:0]      arb_sel;
    logic [IdxW-1:0]      sel;
    logic [IdxW-1:0]      sel_q;
    logic                 lock_q;
    logic [IdxW-1:0]      head;
    logic                 full;
    logic                 empty;
    logic                 handshake;
    logic                 pop;
    logic [CntW-1:0]      cnt_q;

    always_comb begin
        req_vec = '0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            req_vec[i] = mgr_req_i[i].req;
        end
    end

    assign any_req = |req_vec;
    assign arb_sel = IdxW'(rr_select(req_vec, MgrIdxW'(rr_ptr_q)));
    // A request left ungranted keeps its winner so the A-channel stays stable.
    assign sel     = lock_q ? sel_q : arb_sel;

    always_comb begin
        sbr_req_o     = mgr_req_i[sel];
        sbr_req_o.req = any_req & ~full;
    end

    assign handshake = sbr_req_o.req & sbr_rsp_i.gnt;
    assign pop       = sbr_rsp_i.rvalid & ~empty;

    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            mgr_rsp_o[i] = '0;
            if (sel == IdxW'(i)) begin
                mgr_rsp_o[i].gnt = handshake;
            end
            if (pop && (head == IdxW'(i))) begin
                mgr_rsp_o[i].rvalid = 1'b1;
                mgr_rsp_o[i].r      = sbr_rsp_i.r;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            lock_q <= sbr_req_o.req & ~sbr_rsp_i.gnt;
            sel_q  <= sel;
        end
    end

`ifdef USER_OBI_ARB_FIXED_PRIO_EN
    assign rr_ptr_q = '0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    user_obi_arb_fifo #(
        .Width (IdxW),
        .Depth (MaxTrans)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .cnt_o   (cnt_q)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ($bits(sbr_rsp_i.r.rdata) == ObiCfg.DataWidth)
                else $warning("user_obi_arb: response data width differs from ObiCfg");
            assert (!(sbr_rsp_i.rvalid && empty))
                else $warning("user_obi_arb: rvalid with empty queue, response dropped");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_user_obi_arb.sv
//------------------------------------------------------------------------------
// tb_user_obi_arb -- self-checking bench for user_obi_arb (NumMgr=2, MaxTrans=4).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_user_obi_arb;
    import user_obi_arb_pkg::*;

    localparam int N  = 2;
    localparam int MT = 4;
`ifdef USER_OBI_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic     clk   = 1'b0;
    logic     rst_n = 1'b0;
    def_req_t mgr_req [N];
    def_rsp_t mgr_rsp [N];
    def_req_t sbr_req;
    def_rsp_t sbr_rsp;
    int       n_tests = 0;
    int       n_fail  = 0;

    always #5 clk = ~clk;

    user_obi_arb #(
        .obi_req_t (def_req_t),
        .obi_rsp_t (def_rsp_t),
        .NumMgr    (N),
        .MaxTrans  (MT)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .mgr_req_i (mgr_req),
        .mgr_rsp_o (mgr_rsp),
        .sbr_req_o (sbr_req),
        .sbr_rsp_i (sbr_rsp)
    );

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h4926434E : {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic idle();
        for (int i = 0; i < N; i++) mgr_req[i] = '0;
        sbr_rsp = '0;
    endtask

    task automatic set_mgr(input int i, input logic req, input logic [31:0] addr, input logic [3:0] aid);
        mgr_req[i]        = '0;
        mgr_req[i].req    = req;
        mgr_req[i].a.addr = addr;
        mgr_req[i].a.aid  = aid;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if (mgr_rsp[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_mgr_rsp[%0d]: got %h expected 0", i, mgr_rsp[i]);
            end
        end
        n_tests++;
        if (sbr_req.req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sbr_req: got %b expected 0", sbr_req.req);
        end
        n_tests++;
        if (dut.cnt_q !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        set_mgr(0, 1'b1, 32'h0, 4'h3);
        sbr_rsp.gnt = 1'b1;
        #1;
        n_tests++;
        if ({mgr_rsp[1].gnt, mgr_rsp[0].gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_gnt: got %b expected 01", {mgr_rsp[1].gnt, mgr_rsp[0].gnt});
        end
        @(negedge clk);
        set_mgr(0, 1'b0, 32'h0, 4'h0);
        #1;
        n_tests++;
        if ({mgr_rsp[1].rvalid, mgr_rsp[0].rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_early_rvalid: got %b expected 00", {mgr_rsp[1].rvalid, mgr_rsp[0].rvalid});
        end
        @(negedge clk);
        sbr_rsp.rvalid  = 1'b1;
        sbr_rsp.r.rdata = rom(32'h0);
        sbr_rsp.r.rid   = 4'h3;
        #1;
        n_tests++;
        if ({mgr_rsp[1].rvalid, mgr_rsp[0].rvalid} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_rvalid: got %b expected 01", {mgr_rsp[1].rvalid, mgr_rsp[0].rvalid});
        end
        n_tests++;
        if (mgr_rsp[0].r.rdata !== 32'h4926434E || mgr_rsp[0].r.rid !== 4'h3) begin
            n_fail++;
            $display("FAIL single_rdata: got %h/%h expected 4926434e/3", mgr_rsp[0].r.rdata, mgr_rsp[0].r.rid);
        end
        n_tests++;
        if (mgr_rsp[1].r !== '0) begin
            n_fail++;
            $display("FAIL single_other_r: got %h expected 0", mgr_rsp[1].r);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_alternate();
        logic [31:0] hist_addr [8];
        logic [3:0]  hist_aid  [8];
        int          exp_w;
        int          e;
        apply_reset();
        set_mgr(0, 1'b1, 32'h10, 4'h1);
        set_mgr(1, 1'b1, 32'h20, 4'h2);
        for (int t = 0; t < 8; t++) begin
            sbr_rsp     = '0;
            sbr_rsp.gnt = 1'b1;
            if (t >= 2) begin
                sbr_rsp.rvalid  = 1'b1;
                sbr_rsp.r.rdata = rom(hist_addr[t-2]);
                sbr_rsp.r.rid   = hist_aid[t-2];
            end
            #1;
            exp_w = FixedPrio ? 0 : t % 2;
            n_tests++;
            if ({mgr_rsp[1].gnt, mgr_rsp[0].gnt} !== 2'(1 << exp_w)) begin
                n_fail++;
                $display("FAIL alt_gnt cyc %0d: got %b expected %b", t, {mgr_rsp[1].gnt, mgr_rsp[0].gnt}, 2'(1 << exp_w));
            end
            n_tests++;
            if (sbr_req.a.addr !== (exp_w == 1 ? 32'h20 : 32'h10)) begin
                n_fail++;
                $display("FAIL alt_addr cyc %0d: got %h", t, sbr_req.a.addr);
            end
            if (t >= 2) begin
                e = FixedPrio ? 0 : (t - 2) % 2;
                n_tests++;
                if ({mgr_rsp[1].rvalid, mgr_rsp[0].rvalid} !== 2'(1 << e)) begin
                    n_fail++;
                    $display("FAIL alt_rvalid cyc %0d: got %b expected %b", t, {mgr_rsp[1].rvalid, mgr_rsp[0].rvalid}, 2'(1 << e));
                end
                n_tests++;
                if (mgr_rsp[e].r.rid !== (e == 1 ? 4'h2 : 4'h1) ||
                    mgr_rsp[e].r.rdata !== rom(e == 1 ? 32'h20 : 32'h10)) begin
                    n_fail++;
                    $display("FAIL alt_rid cyc %0d: got rid %h rdata %h", t, mgr_rsp[e].r.rid, mgr_rsp[e].r.rdata);
                end
            end
            hist_addr[t] = sbr_req.a.addr;
            hist_aid[t]  = sbr_req.a.aid;
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_lock();
        apply_reset();
        set_mgr(0, 1'b1, 32'h100, 4'h5);
        sbr_rsp.gnt = 1'b1;
        @(negedge clk);
        set_mgr(0, 1'b1, 32'h104, 4'h6);
        sbr_rsp.gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_mgr(1, 1'b1, 32'h204, 4'h7);
            #1;
            n_tests++;
            if (sbr_req.a.addr !== 32'h104 || {mgr_rsp[1].gnt, mgr_rsp[0].gnt} !== 2'b00) begin
                n_fail++;
                $display("FAIL lock_hold cyc %0d: got addr %h gnt %b expected 104/00", k, sbr_req.a.addr, {mgr_rsp[1].gnt, mgr_rsp[0].gnt});
            end
            @(negedge clk);
        end
        sbr_rsp.gnt = 1'b1;
        #1;
        n_tests++;
        if (sbr_req.a.addr !== 32'h104 || {mgr_rsp[1].gnt, mgr_rsp[0].gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_release: got addr %h gnt %b expected 104/01", sbr_req.a.addr, {mgr_rsp[1].gnt, mgr_rsp[0].gnt});
        end
        @(negedge clk);
        set_mgr(0, 1'b0, 32'h0, 4'h0);
        #1;
        n_tests++;
        if (sbr_req.a.addr !== 32'h204 || {mgr_rsp[1].gnt, mgr_rsp[0].gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL lock_next: got addr %h gnt %b expected 204/10", sbr_req.a.addr, {mgr_rsp[1].gnt, mgr_rsp[0].gnt});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full();
        logic exp_req;
        apply_reset();
        set_mgr(0, 1'b1, 32'h10, 4'h1);
        set_mgr(1, 1'b1, 32'h20, 4'h2);
        sbr_rsp.gnt = 1'b1;
        for (int t = 0; t < 6; t++) begin
            #1;
            exp_req = (t < MT);
            n_tests++;
            if (sbr_req.req !== exp_req || (mgr_rsp[0].gnt | mgr_rsp[1].gnt) !== exp_req) begin
                n_fail++;
                $display("FAIL full_issue cyc %0d: got req %b gnt %b%b expected %b", t, sbr_req.req, mgr_rsp[1].gnt, mgr_rsp[0].gnt, exp_req);
            end
            @(negedge clk);
        end
        sbr_rsp.rvalid  = 1'b1;
        sbr_rsp.r.rdata = rom(32'h10);
        sbr_rsp.r.rid   = 4'h1;
        #1;
        n_tests++;
        if (sbr_req.req !== 1'b0 || {mgr_rsp[1].rvalid, mgr_rsp[0].rvalid} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_pop: got req %b rvalid %b expected 0/01", sbr_req.req, {mgr_rsp[1].rvalid, mgr_rsp[0].rvalid});
        end
        @(negedge clk);
        sbr_rsp.rvalid = 1'b0;
        sbr_rsp.r      = '0;
        #1;
        n_tests++;
        if (sbr_req.req !== 1'b1 || (mgr_rsp[0].gnt | mgr_rsp[1].gnt) !== 1'b1) begin
            n_fail++;
            $display("FAIL full_resume: got req %b gnt %b%b expected 1", sbr_req.req, mgr_rsp[1].gnt, mgr_rsp[0].gnt);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_stray();
        apply_reset();
        sbr_rsp.rvalid  = 1'b1;
        sbr_rsp.r.rdata = 32'hDEADBEEF;
        sbr_rsp.r.rid   = 4'h7;
        #1;
        n_tests++;
        if (mgr_rsp[0] !== '0 || mgr_rsp[1] !== '0) begin
            n_fail++;
            $display("FAIL stray_rsp: got %h %h expected 0 0", mgr_rsp[0], mgr_rsp[1]);
        end
        @(negedge clk);
        idle();
        #1;
        n_tests++;
        if (dut.cnt_q !== '0) begin
            n_fail++;
            $display("FAIL stray_cnt: got %0d expected 0", dut.cnt_q);
        end
        // Reset with one transaction outstanding: its late response is dropped.
        set_mgr(0, 1'b1, 32'h30, 4'h1);
        sbr_rsp.gnt = 1'b1;
        @(negedge clk);
        apply_reset();
        sbr_rsp.rvalid  = 1'b1;
        sbr_rsp.r.rdata = rom(32'h30);
        #1;
        n_tests++;
        if ({mgr_rsp[1].rvalid, mgr_rsp[0].rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_rvalid: got %b expected 00", {mgr_rsp[1].rvalid, mgr_rsp[0].rvalid});
        end
        @(negedge clk);
        idle();
        #1;
        n_tests++;
        if (dut.cnt_q !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_cnt: got %0d expected 0", dut.cnt_q);
        end
    endtask

    task automatic test_random();
        int          exp_q [$];
        logic [31:0] sq_addr [$];
        logic [3:0]  sq_aid  [$];
        logic        hold   [N];
        logic [31:0] addr_r [N];
        logic [3:0]  aid_r  [N];
        int          ptr;
        int          pend;
        int          win;
        int          h;
        logic        any;
        logic        ereq;
        logic        rv;
        logic [N-1:0] exp_g, got_g, exp_rv, got_rv;
        apply_reset();
        ptr  = 0;
        pend = -1;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i] && $urandom_range(0, 99) < 60) begin
                    hold[i]        = 1'b1;
                    addr_r[i]      = $urandom();
                    addr_r[i][1:0] = 2'b00;
                    aid_r[i]       = 4'($urandom());
                end
                set_mgr(i, hold[i], addr_r[i], aid_r[i]);
            end
            sbr_rsp     = '0;
            sbr_rsp.gnt = ($urandom_range(0, 3) != 0);
            rv = (sq_addr.size() > 0) && ($urandom_range(0, 2) != 0);
            if (rv) begin
                sbr_rsp.rvalid  = 1'b1;
                sbr_rsp.r.rdata = rom(sq_addr[0]);
                sbr_rsp.r.rid   = sq_aid[0];
            end
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= hold[i];
            ereq = any && (exp_q.size() < MT);
            win  = pend;
            if (win < 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (hold[(ptr + k) % N]) win = (ptr + k) % N;
                end
            end
            exp_g  = '0;
            exp_rv = '0;
            if (ereq && sbr_rsp.gnt) exp_g[win] = 1'b1;
            h = rv ? exp_q[0] : 0;
            if (rv) exp_rv[h] = 1'b1;
            #1;
            for (int i = 0; i < N; i++) begin
                got_g[i]  = mgr_rsp[i].gnt;
                got_rv[i] = mgr_rsp[i].rvalid;
            end
            n_tests++;
            if (sbr_req.req !== ereq || got_g !== exp_g || (ereq && sbr_req.a.addr !== addr_r[win])) begin
                n_fail++;
                $display("FAIL rand_req cyc %0d: got req %b gnt %b addr %h expected %b %b %h",
                         cyc, sbr_req.req, got_g, sbr_req.a.addr, ereq, exp_g, ereq ? addr_r[win] : 32'h0);
            end
            n_tests++;
            if (got_rv !== exp_rv || (rv && (mgr_rsp[h].r.rdata !== rom(sq_addr[0]) || mgr_rsp[h].r.rid !== sq_aid[0]))) begin
                n_fail++;
                $display("FAIL rand_rsp cyc %0d: got rvalid %b rdata %h expected %b %h",
                         cyc, got_rv, mgr_rsp[h].r.rdata, exp_rv, rv ? rom(sq_addr[0]) : 32'h0);
            end
            if (rv) begin
                void'(exp_q.pop_front());
                void'(sq_addr.pop_front());
                void'(sq_aid.pop_front());
            end
            if (ereq && sbr_rsp.gnt) begin
                exp_q.push_back(win);
                sq_addr.push_back(addr_r[win]);
                sq_aid.push_back(aid_r[win]);
                if (!FixedPrio) ptr = (win + 1) % N;
                hold[win] = 1'b0;
                pend      = -1;
            end else if (ereq) begin
                pend = win;
            end else begin
                pend = -1;
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_full();
        test_stray();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
